// File: rtl/stream_demux_1ton.sv
// 1-to-N valid/ready stream demultiplexer with one registered holding stage,
// per-beat or packet-locked channel select, and counting of dropped beats.
module stream_demux_1ton #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_last,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_last,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic               err,
  output logic [7:0]         err_cnt
);

  typedef enum logic [1:0] {SOP, LOCK, DROP} state_e;

  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N);

  state_e            state_q, state_d;
  logic              hv_q, hv_d;
  logic [SEL_W-1:0]  hch_q, hch_d;
  logic [WIDTH-1:0]  hdata_q, hdata_d;
  logic              hlast_q, hlast_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              drain;
  logic              accept;
  logic              beat_ok;
  logic [SEL_W-1:0]  ch;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (hv_q && hch_q == SEL_W'(k)) begin
        out_valid[k]                 = 1'b1;
        out_data[k*WIDTH +: WIDTH]   = hdata_q;
        out_last[k]                  = hlast_q;
      end
    end
  end

  // drain is equivalent to hv && out_ready[hch] but never indexes past N-1
  assign drain    = |(out_valid & out_ready);
  assign in_ready = rst_n && (!hv_q || drain);
  assign accept   = in_valid && in_ready;
  assign ch       = (state_q == LOCK) ? lock_ch_q : in_sel;
  assign beat_ok  = (state_q != DROP) && ({1'b0, ch} < N_LIM);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    hv_d      = hv_q;
    hch_d     = hch_q;
    hdata_d   = hdata_q;
    hlast_d   = hlast_q;
    lock_ch_d = lock_ch_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (drain) hv_d = 1'b0;

    if (accept) begin
      if (beat_ok) begin
        hv_d    = 1'b1;
        hch_d   = ch;
        hdata_d = in_data;
        hlast_d = in_last;
      end else begin
        err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
      end

      // mode only matters at start of packet; mid-packet changes wait for in_last
      unique case (state_q)
        SOP: begin
          if (mode && !in_last) begin
            if (beat_ok) begin
              state_d   = LOCK;
              lock_ch_d = ch;
            end else begin
              state_d = DROP;
            end
          end
        end
        LOCK, DROP: if (in_last) state_d = SOP;
        default: state_d = SOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SOP;
      hv_q      <= 1'b0;
      hch_q     <= '0;
      hdata_q   <= '0;
      hlast_q   <= 1'b0;
      lock_ch_q <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hv_q      <= hv_d;
      hch_q     <= hch_d;
      hdata_q   <= hdata_d;
      hlast_q   <= hlast_d;
      lock_ch_q <= lock_ch_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton with N=3 so that select value 3 is
// an invalid channel; directed scenarios followed by randomized traffic.
module tb_stream_demux_1ton;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               mode;
  logic [WIDTH-1:0]   in_data;
  logic [SEL_W-1:0]   in_sel;
  logic               in_last;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_last;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
  logic               err;
  logic [7:0]         err_cnt;

  stream_demux_1ton #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_sel(in_sel),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    acc_flag = 0;
  bit    exp_err  = 0;
  int    exp_cnt  = 0;
  bit    in_pkt   = 0;
  int    pkt_ch   = 0;
  bit    rand_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet started in mode 1 pins its channel (possibly an
  // invalid one) until in_last; otherwise every beat uses its own select.
  function automatic void model_step();
    int c;
    if (!in_pkt) begin
      c = int'(in_sel);
      if (mode && !in_last) begin
        in_pkt = 1;
        pkt_ch = c;
      end
    end else begin
      c = pkt_ch;
      if (in_last) in_pkt = 0;
    end
    if (c < N) q.push_back('{c, in_data, in_last});
    else begin
      exp_err = 1;
      if (exp_cnt < 255) exp_cnt++;
    end
  endfunction

  // Issue side: acceptance is decided mid-cycle, expectations pushed just after.
  always @(negedge clk) begin
    bit acc;
    acc = rst_n && in_valid && in_ready;
    #1;
    exp_err  = 0;
    acc_flag = acc;
    if (acc) model_step();
  end

  // Monitor: compares the outputs with the scoreboard head each cycle.
  always @(negedge clk) begin
    logic [N-1:0]       ev;
    logic [N*WIDTH-1:0] ed;
    logic [N-1:0]       el;
    logic               er;
    if (rst_n) begin
      ev = '0; ed = '0; el = '0; er = 1'b1;
      if (q.size() > 0) begin
        ev[q[0].ch]           = 1'b1;
        ed[q[0].ch*WIDTH +: WIDTH] = q[0].data;
        el[q[0].ch]           = q[0].last;
        er                    = out_ready[q[0].ch];
      end
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_data", 32'(out_data), 32'(ed));
      check("out_last", 32'(out_last), 32'(el));
      check("err", 32'(err), 32'(exp_err));
      check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      if (q.size() > 0 && out_ready[q[0].ch]) void'(q.pop_front());
    end
  end

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l, input logic m);
    int unsigned w = 0;
    in_data = d; in_sel = s; in_last = l; mode = m; in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      w++;
      if (!acc_flag && rand_rdy) out_ready = N'($urandom);
    end while (!acc_flag && w < 200);
    if (!acc_flag) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: beat %0h not accepted after %0d cycles", d, w);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = N'($urandom);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    q.delete();
    in_pkt = 0; exp_cnt = 0; exp_err = 0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; in_data = '0; in_sel = '0;
    in_last = 1'b0; out_ready = '1;
    repeat (2) @(posedge clk);
    #1 do_reset();

    // per-beat routing on consecutive cycles
    for (int i = 0; i < N; i++) send(8'hA0 + 8'(i), 2'(i), 1'b1, 1'b0);
    idle(2);

    // packet lock on channel 2, then a single beat to channel 1
    send(8'hC0, 2'd2, 1'b0, 1'b1);
    send(8'hC1, 2'd0, 1'b0, 1'b1);
    send(8'hC2, 2'd3, 1'b1, 1'b1);
    send(8'hC3, 2'd1, 1'b1, 1'b1);
    idle(2);

    // backpressure on channel 1, release overlaps drain with next accept
    out_ready = 3'b101;
    send(8'hB1, 2'd1, 1'b1, 1'b0);
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = '1;
      end
    join_none
    send(8'hB2, 2'd0, 1'b1, 1'b0);
    idle(2);

    // invalid selects: single beat, dropped 4-beat packet, saturation
    send(8'hD0, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hD1 + 8'(i), (i == 0) ? 2'd3 : 2'd0, (i == 3), 1'b1);
    send(8'hD8, 2'd1, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) send(8'(i), 2'd3, 1'b1, 1'b0);
    idle(2);

    // reset while locked on channel 2 with a beat stalled in the holding stage
    send(8'hE0, 2'd2, 1'b0, 1'b1);
    out_ready = '0;
    idle(2);
    do_reset();
    out_ready = '1;
    send(8'hE1, 2'd0, 1'b1, 1'b1);
    idle(2);

    // mode drops to 0 mid-packet: lock holds until in_last
    send(8'hF0, 2'd1, 1'b0, 1'b1);
    send(8'hF1, 2'd0, 1'b0, 1'b0);
    send(8'hF2, 2'd2, 1'b1, 1'b0);
    send(8'hF3, 2'd0, 1'b0, 1'b0);
    send(8'hF4, 2'd2, 1'b0, 1'b0);
    idle(2);

    // randomized traffic with random backpressure and gaps
    rand_rdy = 1;
    repeat (400) begin
      send(8'($urandom), 2'($urandom), ($urandom_range(3) == 0), ($urandom_range(2) == 0));
      if ($urandom_range(3) == 0) idle($urandom_range(2, 1));
    end
    rand_rdy = 0;
    out_ready = '1;
    idle(4);
    check("drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1ton

Parametrised 1-to-N stream demultiplexer with a valid/ready handshake. It is the successor to the gate-level 1-to-2 demux. The block routes each beat of a WIDTH-bit input stream to one of N output channels through a single registered holding stage. It supports per-beat or per-packet channel selection, drops beats that carry an invalid select, and counts the dropped beats. It sits between a single producer and N independent consumers in the datapath.

## Interface
- WIDTH, 8: data width per beat.
- N, 4: number of output channels, 2..2**SEL_W.
- SEL_W, 2: select width.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- mode  input  1  0 = per-beat select, 1 = packet lock (select sampled on first beat, held through in_last).
- in_data  input  WIDTH  input beat.
- in_sel  input  SEL_W  destination channel for the beat.
- in_last  input  1  final beat of packet.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  N*WIDTH  slice k = channel k data; slices not currently valid drive zero.
- out_last  output  N  per-channel last flag; zero when not valid.
- out_valid  output  N  one-hot or zero.
- out_ready  input  N  per-channel consumer ready.
- err  output  1  one-cycle pulse when a beat is dropped.
- err_cnt  output  8  saturating count of dropped beats.

## Operation
- Holding register: hv (valid), hch (channel), hdata, hlast. out_valid[k] = hv && hch==k. out_data and out_last are masked by out_valid.
- in_ready = rst_n && (!hv || out_ready[hch]). Acceptance = in_valid && in_ready.
- Effective channel ch:
  - mode 0: ch = in_sel.
  - mode 1: ch = in_sel in state SOP, locked channel in state LOCK.
- Beat valid iff ch < N. If valid, load the holding register (hv=1). Otherwise drop the beat: hv cleared unless the current beat is still stalled, err=1, and err_cnt increments, saturating at 255.
- An invalid beat is accepted under the same in_ready rule. It never reaches any output.
- FSM, evaluated only on an accepted beat:
  - SOP: mode 1, select valid, !in_last -> LOCK (latch ch). Mode 1, select invalid, !in_last -> DROP. Otherwise stay in SOP.
  - LOCK: in_last -> SOP. The in_sel value is ignored while in LOCK.
  - DROP: every beat is dropped (err pulse, counter increments). in_last -> SOP.
- mode is sampled only in SOP. A change mid-packet takes effect after in_last.
- Holding-register output leaves when out_valid[k] && out_ready[k]. A simultaneous drain and accept reloads in the same cycle (full throughput).

## Timing
- Latency: an accepted beat appears on its out_valid the next cycle.
- Throughput: 1 beat/cycle while the destination consumer holds out_ready high.
- Stall: hv=1 and out_ready[hch]=0 -> in_ready=0. Holding data, channel and last remain stable.
- Backpressure on one channel blocks all channels; head-of-line blocking is intended.
- err is a registered pulse, asserted the cycle after the dropping acceptance.
- Reset (rst_n low, at any time including mid-packet or mid-stall), applied immediately and asynchronously:
  - hv=0, out_valid=0, out_data=0, out_last=0, err=0, err_cnt=0, FSM=SOP, locked channel=0.
  - in_ready=0 while rst_n is low.
  - A beat held at reset is lost.
- First acceptance is possible on the first rising edge after rst_n deasserts.

## Test plan
- Per-beat routing: N=4, mode 0, all out_ready=1. Beats 0xA0..0xA3 with in_sel 0,1,2,3 on consecutive cycles -> out_valid 0001,0010,0100,1000 on cycles 1..4. Data appears on the matching slice, other slices are zero, and in_ready stays 1.
- Packet lock: mode 1, 3-beat packet with in_sel 2,0,3 and in_last on beat 3 -> all three beats appear on channel 2 with out_last[2] on the third. The following beat with in_sel 1 goes to channel 1.
- Backpressure: beat to channel 1 with out_ready[1]=0 for 3 cycles -> in_ready=0 for those cycles and out_data slice 1 is stable. When out_ready[1] rises, the drain and the next beat's accept occur in the same cycle.
- Invalid select: N=3, mode 0, in_sel=3 -> no out_valid, err pulses once, err_cnt=1. In mode 1, a 4-beat packet starting with sel 3 -> err_cnt +4 and FSM back in SOP. Driving 300 bad beats -> err_cnt holds 255.
- Reset mid-packet: mode 1 with LOCK on channel 2 and a beat stalled in the holding register; pulse rst_n low mid-cycle -> outputs clear immediately. The next beat with in_sel 0 routes to channel 0.
- Mode change mid-packet: switch mode 1->0 during LOCK -> remaining beats stay locked until in_last. The subsequent beats follow per-beat in_sel.
